// File: rtl/alu_core_if.sv
// alu_core_if: operand/control bundle for the two-stage ALU.
//   master : drives operand buses, operand/op selects, carry-in, decimal
//            enables and the start strobe; receives result and status.
//   slave  : the ALU side (alu_core).
//   Signals: sb_bus/db_bus/adl_bus (8b operands), sb_add/zero_add (A select),
//            db_add/ndb_add/adl_add (B select), sums/ands/eors/ors/srs (op),
//            i_addc (carry / shift-in), daa/dsa (decimal correction),
//            op_start, alu_to_add (8b result), acr/avr/hc (flags), busy, done.
interface alu_core_if;
  logic [7:0] sb_bus;
  logic [7:0] db_bus;
  logic [7:0] adl_bus;
  logic       sb_add;
  logic       zero_add;
  logic       db_add;
  logic       ndb_add;
  logic       adl_add;
  logic       sums;
  logic       ands;
  logic       eors;
  logic       ors;
  logic       srs;
  logic       i_addc;
  logic       daa;
  logic       dsa;
  logic       op_start;
  logic [7:0] alu_to_add;
  logic       acr;
  logic       avr;
  logic       hc;
  logic       busy;
  logic       done;

  modport master (
    output sb_bus, db_bus, adl_bus, sb_add, zero_add, db_add, ndb_add, adl_add,
           sums, ands, eors, ors, srs, i_addc, daa, dsa, op_start,
    input  alu_to_add, acr, avr, hc, busy, done
  );

  modport slave (
    input  sb_bus, db_bus, adl_bus, sb_add, zero_add, db_add, ndb_add, adl_add,
           sums, ands, eors, ors, srs, i_addc, daa, dsa, op_start,
    output alu_to_add, acr, avr, hc, busy, done
  );
endinterface

// File: rtl/alu_core.sv
// alu_core: two-stage 8-bit ALU feeding the adder hold register.
//   Latches operands on a start strobe (IDLE), computes sum/logic/shift with
//   carry, overflow and half-carry in EXEC, optionally applies a decimal
//   correction in ADJ, and pulses done for one cycle with the result.
// Ports:
//   phi_2  : clock, rising edge
//   reset  : asynchronous, active-high; clears state, operands and outputs
//   bus    : alu_core_if.slave (operands, selects, op, flags, busy, done)
module alu_core (
  input  logic        phi_2,
  input  logic        reset,
  alu_core_if.slave   bus
);

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ADJ} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_SUM, OP_AND, OP_EOR, OP_OR, OP_SRS} op_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] a_p0, b_p0;
  op_t               op_p0;
  logic              cin_p0, daa_p0, dsa_p0;

  logic [DATA_W-1:0] res_p1;
  logic              acr_p1, avr_p1, hc_p1, done_p1;

  logic [DATA_W-1:0] a_sel, b_sel;
  op_t               op_sel;

  logic              lat_en, exec_en, adj_en, done_set, adj_needed;

  logic [DATA_W:0]   sum_w;
  logic [DATA_W-1:0] exec_res;
  logic              exec_acr, exec_avr, exec_hc;
  logic [DATA_W-1:0] adj_res;
  logic              adj_acr;

  // Decimal add correction: returns {carry, corrected byte}.
  function automatic logic [DATA_W:0] daa_fix(input logic [DATA_W-1:0] r,
                                              input logic c, input logic h);
    logic [DATA_W-1:0] t;
    logic              co;
    t  = r;
    co = c;
    if (h || (t[3:0] > 4'd9)) t = t + 8'h06;
    if (co || (t[7:4] > 4'd9)) begin
      t  = t + 8'h60;
      co = 1'b1;
    end
    return {co, t};
  endfunction

  // Decimal subtract correction: each nibble wraps on its own, no borrow.
  function automatic logic [DATA_W-1:0] dsa_fix(input logic [DATA_W-1:0] r,
                                                input logic c, input logic h);
    logic [3:0] lo, hi;
    lo = r[3:0];
    hi = r[7:4];
    if (!h) lo = lo - 4'd6;
    if (!c) hi = hi - 4'd6;
    return {hi, lo};
  endfunction

  // Operand / op selection at the start edge; unselected operands hold.
  always_comb begin
    a_sel = a_p0;
    if (bus.sb_add)        a_sel = bus.sb_bus;
    else if (bus.zero_add) a_sel = '0;

    b_sel = b_p0;
    if (bus.db_add)        b_sel = bus.db_bus;
    else if (bus.ndb_add)  b_sel = ~bus.db_bus;
    else if (bus.adl_add)  b_sel = bus.adl_bus;

    op_sel = OP_NONE;
    if (bus.sums)      op_sel = OP_SUM;
    else if (bus.ands) op_sel = OP_AND;
    else if (bus.eors) op_sel = OP_EOR;
    else if (bus.ors)  op_sel = OP_OR;
    else if (bus.srs)  op_sel = OP_SRS;
  end

  // EXEC datapath
  always_comb begin
    sum_w    = {1'b0, a_p0} + {1'b0, b_p0} + {{DATA_W{1'b0}}, cin_p0};
    exec_res = '0;
    exec_acr = 1'b0;
    exec_avr = 1'b0;
    exec_hc  = 1'b0;
    unique case (op_p0)
      OP_SUM: begin
        exec_res = sum_w[DATA_W-1:0];
        exec_acr = sum_w[DATA_W];
        exec_hc  = (5'(a_p0[3:0]) + 5'(b_p0[3:0]) + 5'(cin_p0)) > 5'd15;
        exec_avr = (a_p0[7] == b_p0[7]) && (sum_w[7] != a_p0[7]);
      end
      OP_AND:  exec_res = a_p0 & b_p0;
      OP_EOR:  exec_res = a_p0 ^ b_p0;
      OP_OR:   exec_res = a_p0 | b_p0;
      OP_SRS: begin
        exec_res = {cin_p0, a_p0[7:1]};
        exec_acr = a_p0[0];
      end
      default: ;
    endcase
  end

  // ADJ datapath; decimal add takes precedence when both are latched.
  always_comb begin
    adj_res = res_p1;
    adj_acr = acr_p1;
    if (daa_p0) {adj_acr, adj_res} = daa_fix(res_p1, acr_p1, hc_p1);
    else        adj_res = dsa_fix(res_p1, acr_p1, hc_p1);
  end

  assign adj_needed = (op_p0 == OP_SUM) && (daa_p0 || dsa_p0);

  // FSM: state register
  always_ff @(posedge phi_2 or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (bus.op_start) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = adj_needed ? S_ADJ : S_IDLE;
      S_ADJ:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs / stage enables
  always_comb begin
    lat_en   = 1'b0;
    exec_en  = 1'b0;
    adj_en   = 1'b0;
    done_set = 1'b0;
    unique case (state)
      S_IDLE: lat_en = bus.op_start;
      S_EXEC: begin
        exec_en  = 1'b1;
        done_set = !adj_needed;
      end
      S_ADJ: begin
        adj_en   = 1'b1;
        done_set = 1'b1;
      end
      default: ;
    endcase
  end

  // Stage p0: operand latch
  always_ff @(posedge phi_2 or posedge reset) begin
    if (reset) begin
      a_p0   <= '0;
      b_p0   <= '0;
      op_p0  <= OP_NONE;
      cin_p0 <= 1'b0;
      daa_p0 <= 1'b0;
      dsa_p0 <= 1'b0;
    end else if (lat_en) begin
      a_p0   <= a_sel;
      b_p0   <= b_sel;
      op_p0  <= op_sel;
      cin_p0 <= bus.i_addc;
      daa_p0 <= bus.daa;
      dsa_p0 <= bus.dsa;
    end
  end

  // Stage p1: result and flags (EXEC writes all, ADJ rewrites result/carry)
  always_ff @(posedge phi_2 or posedge reset) begin
    if (reset) begin
      res_p1  <= '0;
      acr_p1  <= 1'b0;
      avr_p1  <= 1'b0;
      hc_p1   <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      done_p1 <= done_set;
      if (exec_en) begin
        res_p1 <= exec_res;
        acr_p1 <= exec_acr;
        avr_p1 <= exec_avr;
        hc_p1  <= exec_hc;
      end else if (adj_en) begin
        res_p1 <= adj_res;
        acr_p1 <= adj_acr;
      end
    end
  end

  assign bus.alu_to_add = res_p1;
  assign bus.acr        = acr_p1;
  assign bus.avr        = avr_p1;
  assign bus.hc         = hc_p1;
  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = done_p1;

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;

  logic phi_2 = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  alu_core_if bus ();

  alu_core dut (
    .phi_2 (phi_2),
    .reset (reset),
    .bus   (bus)
  );

  always #5 phi_2 = ~phi_2;
  always @(posedge phi_2) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] sb, db, adl;
    logic sb_add, zero_add, db_add, ndb_add, adl_add;
    logic sums, ands, eors, ors, srs;
    logic cin, daa, dsa, start;
  } stim_t;

  typedef struct {
    int res, acr, avr, hc, cyc;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   ma = 0, mb = 0;   // model operand registers
  int   skip = 0;         // model: busy cycles remaining

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: plain integer arithmetic from the operation rules.
  task automatic accept(input stim_t s);
    int a, b, cin, res, acr, avr, hc, adj, ss, lo, hi;
    exp_t e;
    a   = s.sb_add ? int'(s.sb) : s.zero_add ? 0 : ma;
    b   = s.db_add ? int'(s.db) : s.ndb_add ? 255 - int'(s.db) : s.adl_add ? int'(s.adl) : mb;
    ma  = a;
    mb  = b;
    cin = int'(s.cin);
    res = 0; acr = 0; avr = 0; hc = 0; adj = 0;
    if (s.sums) begin
      res = a + b + cin;
      acr = (res > 255);
      res = res % 256;
      hc  = ((a % 16) + (b % 16) + cin) > 15;
      ss  = (a > 127 ? a - 256 : a) + (b > 127 ? b - 256 : b) + cin;
      avr = (ss > 127) || (ss < -128);
      if (s.daa) begin
        adj = 1;
        if (hc || (res % 16) > 9) res = (res + 6) % 256;
        if (acr || (res / 16) > 9) begin
          res = (res + 96) % 256;
          acr = 1;
        end
      end else if (s.dsa) begin
        adj = 1;
        lo = res % 16;
        hi = res / 16;
        if (!hc)  lo = (lo + 10) % 16;
        if (!acr) hi = (hi + 10) % 16;
        res = hi * 16 + lo;
      end
    end else if (s.ands) res = a & b;
    else if (s.eors) res = a ^ b;
    else if (s.ors)  res = a | b;
    else if (s.srs) begin
      res = cin * 128 + a / 2;
      acr = a % 2;
    end
    e.res = res; e.acr = acr; e.avr = avr; e.hc = hc;
    e.cyc = cyc + 1 + adj;
    exp_q.push_back(e);
    skip = adj ? 2 : 1;
  endtask

  task automatic drive(input stim_t s);
    bus.sb_bus = s.sb;   bus.db_bus = s.db;     bus.adl_bus = s.adl;
    bus.sb_add = s.sb_add; bus.zero_add = s.zero_add;
    bus.db_add = s.db_add; bus.ndb_add = s.ndb_add; bus.adl_add = s.adl_add;
    bus.sums = s.sums; bus.ands = s.ands; bus.eors = s.eors;
    bus.ors = s.ors;   bus.srs = s.srs;
    bus.i_addc = s.cin; bus.daa = s.daa; bus.dsa = s.dsa;
    bus.op_start = s.start;
    @(posedge phi_2);
    #1;
    if (reset) skip = 0;
    else if (skip == 0 && s.start) accept(s);
    else if (skip > 0) skip--;
    chk("busy", int'(bus.busy), int'(skip > 0));
  endtask

  task automatic idle(input int n);
    stim_t s;
    s = '0;
    for (int i = 0; i < n; i++) drive(s);
  endtask

  task automatic expect_out(input string name, input int res, input int acr,
                            input int avr, input int hc);
    chk({name, "_res"}, int'(bus.alu_to_add), res);
    chk({name, "_acr"}, int'(bus.acr), acr);
    chk({name, "_avr"}, int'(bus.avr), avr);
    chk({name, "_hc"},  int'(bus.hc), hc);
  endtask

  function automatic stim_t op_ab(input logic [7:0] sb, input logic [7:0] db);
    stim_t s;
    s = '0;
    s.sb = sb; s.db = db;
    s.sb_add = 1'b1; s.db_add = 1'b1; s.start = 1'b1;
    return s;
  endfunction

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge phi_2) begin
    if (bus.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res", int'(bus.alu_to_add), e.res);
        chk("acr", int'(bus.acr), e.acr);
        chk("avr", int'(bus.avr), e.avr);
        chk("hc",  int'(bus.hc), e.hc);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    stim_t s, s2;
    bus.sb_bus = '0; bus.db_bus = '0; bus.adl_bus = '0;
    bus.sb_add = 0; bus.zero_add = 0; bus.db_add = 0; bus.ndb_add = 0; bus.adl_add = 0;
    bus.sums = 0; bus.ands = 0; bus.eors = 0; bus.ors = 0; bus.srs = 0;
    bus.i_addc = 0; bus.daa = 0; bus.dsa = 0; bus.op_start = 0;

    repeat (2) @(posedge phi_2);
    #1;
    expect_out("reset", 0, 0, 0, 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    reset = 1'b0;

    // Binary add with signed overflow
    s = op_ab(8'h50, 8'h50); s.sums = 1; drive(s); idle(3);
    expect_out("bin_add", 8'hA0, 0, 1, 0);

    // Decimal add
    s = op_ab(8'h19, 8'h28); s.sums = 1; s.daa = 1; drive(s); idle(4);
    expect_out("daa_1928", 8'h47, 0, 0, 1);
    s = op_ab(8'h99, 8'h01); s.sums = 1; s.daa = 1; drive(s); idle(4);
    chk("daa_9901_res", int'(bus.alu_to_add), 8'h00);
    chk("daa_9901_acr", int'(bus.acr), 1);

    // Decimal subtract
    s = op_ab(8'h42, 8'h15); s.db_add = 0; s.ndb_add = 1; s.cin = 1;
    s.sums = 1; s.dsa = 1; drive(s); idle(4);
    expect_out("dsa_4215", 8'h27, 1, 0, 0);

    // Logic ops and shift
    s = op_ab(8'hF0, 8'h3C); s.ands = 1; drive(s); idle(3);
    expect_out("and", 8'h30, 0, 0, 0);
    s = op_ab(8'hF0, 8'h3C); s.eors = 1; drive(s); idle(3);
    expect_out("eor", 8'hCC, 0, 0, 0);
    s = op_ab(8'hF0, 8'h3C); s.ors = 1; drive(s); idle(3);
    expect_out("or", 8'hFC, 0, 0, 0);
    s = op_ab(8'h81, 8'h00); s.srs = 1; s.cin = 1; drive(s); idle(3);
    chk("srs_res", int'(bus.alu_to_add), 8'hC0);
    chk("srs_acr", int'(bus.acr), 1);
    s = op_ab(8'h50, 8'h50); s.sums = 1; s.ands = 1; drive(s); idle(3);
    chk("sum_prio_res", int'(bus.alu_to_add), 8'hA0);

    // Second start during EXEC is ignored
    s  = op_ab(8'h12, 8'h34); s.sums = 1;
    s2 = op_ab(8'hAA, 8'h55); s2.ors = 1;
    drive(s); drive(s2); idle(3);
    chk("ignored_start_res", int'(bus.alu_to_add), 8'h46);

    // Reset during ADJ of a decimal add
    s = op_ab(8'h19, 8'h28); s.sums = 1; s.daa = 1;
    drive(s); idle(1);
    reset = 1'b1;
    #1;
    expect_out("midreset", 0, 0, 0, 0);
    chk("midreset_busy", int'(bus.busy), 0);
    chk("midreset_done", int'(bus.done), 0);
    exp_q.delete();
    skip = 0; ma = 0; mb = 0;
    idle(2);
    reset = 1'b0;
    idle(3);
    s = op_ab(8'h01, 8'h01); s.sums = 1; drive(s); idle(3);
    chk("post_reset_res", int'(bus.alu_to_add), 8'h02);

    // Randomized: a block with start held high, then random starts
    for (int i = 0; i < 600; i++) begin
      int sel;
      s = '0;
      s.sb = 8'($urandom); s.db = 8'($urandom); s.adl = 8'($urandom);
      s.sb_add   = 1'($urandom_range(0, 1));
      s.zero_add = 1'($urandom_range(0, 1));
      s.db_add   = 1'($urandom_range(0, 2) == 0);
      s.ndb_add  = 1'($urandom_range(0, 1));
      s.adl_add  = 1'($urandom_range(0, 1));
      s.cin      = 1'($urandom_range(0, 1));
      s.daa      = 1'($urandom_range(0, 2) == 0);
      s.dsa      = 1'($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1: s.sums = 1;
        2: s.ands = 1;
        3: s.eors = 1;
        4: s.ors = 1;
        5: s.srs = 1;
        6: ;
        default: {s.sums, s.ands, s.eors, s.ors, s.srs} = 5'($urandom);
      endcase
      s.start = (i < 150) ? 1'b1 : 1'($urandom_range(0, 1));
      drive(s);
    end
    idle(5);
    chk("pending_ops", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
